// File: rtl/cpc_ram_pkg.sv
// rtl/cpc_ram_pkg.sv - shared types and constants for the CPC 512K RAM bank decoder
package cpc_ram_pkg;

  // Config-snoop FSM: wait for the OUT to finish before applying it.
  typedef enum logic [1:0] {
    IO_IDLE   = 2'd0,
    IO_WAIT   = 2'd1,
    IO_COMMIT = 2'd2
  } io_state_e;

  localparam int MODE_W = 3;

  // Gate-array function select for RAM configuration: D[7:6]
  localparam logic [1:0] CFG_SEL = 2'b11;

  // Page per 16K window [mode][window]; page[2] set means expansion RAM.
  localparam logic [2:0] PAGE_MAP [8][4] = '{
    '{3'd0, 3'd1, 3'd2, 3'd3},
    '{3'd0, 3'd1, 3'd2, 3'd7},
    '{3'd4, 3'd5, 3'd6, 3'd7},
    '{3'd0, 3'd3, 3'd2, 3'd7},
    '{3'd0, 3'd4, 3'd2, 3'd3},
    '{3'd0, 3'd5, 3'd2, 3'd3},
    '{3'd0, 3'd6, 3'd2, 3'd3},
    '{3'd0, 3'd7, 3'd2, 3'd3}
  };

endpackage

// File: rtl/cpc_ram_bank_decoder_if.sv
// rtl/cpc_ram_bank_decoder_if.sv - Z80 edge-connector bus and SRAM control bundle
interface cpc_ram_bank_decoder_if #(
  parameter int HIADR_W = 5
);
  logic               A15;
  logic               A14;
  logic [7:0]         D;
  logic               MREQ_B;
  logic               IOREQ_B;
  logic               WR_B;
  logic               RFSH_B;
  logic               M1_B;
  logic               RAMRD_B;
  logic [HIADR_W-1:0] HIADR;
  logic               RAMCS_B;
  logic               RAMDIS;

  // CPC side: drives the bus, observes the decoder outputs
  modport master (
    output A15, A14, D, MREQ_B, IOREQ_B, WR_B, RFSH_B, M1_B, RAMRD_B,
    input  HIADR, RAMCS_B, RAMDIS
  );

  // Decoder side
  modport slave (
    input  A15, A14, D, MREQ_B, IOREQ_B, WR_B, RFSH_B, M1_B, RAMRD_B,
    output HIADR, RAMCS_B, RAMDIS
  );
endinterface

// File: rtl/cpc_bank_map.sv
// rtl/cpc_bank_map.sv - (mode, 16K window) to page lookup
module cpc_bank_map
  import cpc_ram_pkg::*;
(
  input  logic [MODE_W-1:0] mode,
  input  logic [1:0]        window,
  output logic [2:0]        page
);

  assign page = PAGE_MAP[mode][window];

endmodule

// File: rtl/cpc_ram_bank_decoder.sv
// rtl/cpc_ram_bank_decoder.sv - config snoop, bank registers and SRAM select gating
module cpc_ram_bank_decoder
  import cpc_ram_pkg::*;
#(
  parameter int BANK_BITS = 3,
  parameter int HIADR_W   = 5
) (
  input  logic                   CLK,
  input  logic                   RESET,
  cpc_ram_bank_decoder_if.slave  bus
);

  io_state_e              io_state;
  logic [BANK_BITS-1:0]   cfg_bank;
  logic [MODE_W-1:0]      cfg_mode;
  logic [BANK_BITS-1:0]   pend_bank;
  logic [MODE_W-1:0]      pend_mode;
  logic [HIADR_W-1:0]     hiadr_q;
  logic [HIADR_W-1:0]     hiadr_new;
  logic [2:0]             pg;
  logic                   cfg_wr;
  logic                   exp_hit;
  logic                   acc;

  // Gate-array RAM-config write; int-ack (M1 low) and A15=1 ports are not the gate array.
  assign cfg_wr = !bus.IOREQ_B && !bus.WR_B && bus.M1_B && !bus.A15 &&
                  (bus.D[7:6] == CFG_SEL);

  // Capture config during the OUT, apply it only once IOREQ has gone away.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      io_state  <= IO_IDLE;
      cfg_bank  <= '0;
      cfg_mode  <= '0;
      pend_bank <= '0;
      pend_mode <= '0;
    end else begin
      case (io_state)
        IO_IDLE: begin
          if (cfg_wr) begin
            pend_bank <= bus.D[3 +: BANK_BITS];
            pend_mode <= bus.D[MODE_W-1:0];
            io_state  <= IO_WAIT;
          end
        end
        IO_WAIT: begin
          if (bus.IOREQ_B) begin
            io_state <= IO_COMMIT;
          end else if (cfg_wr) begin
            pend_bank <= bus.D[3 +: BANK_BITS];
            pend_mode <= bus.D[MODE_W-1:0];
          end
        end
        IO_COMMIT: begin
          cfg_bank <= pend_bank;
          cfg_mode <= pend_mode;
          io_state <= IO_IDLE;
        end
        default: io_state <= IO_IDLE;
      endcase
    end
  end

  cpc_bank_map u_map (
    .mode   (cfg_mode),
    .window ({bus.A15, bus.A14}),
    .page   (pg)
  );

  assign exp_hit   = pg[2];
  assign hiadr_new = {cfg_bank, pg[1:0]};

  // Keep the last expansion address so HIADR stays quiet on internal accesses.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hiadr_q <= '0;
    end else if (exp_hit) begin
      hiadr_q <= hiadr_new;
    end
  end

  // Refresh and ROM reads never reach the SRAM; writes under ROM still do.
  assign acc = !bus.MREQ_B && bus.RFSH_B && (!bus.RAMRD_B || !bus.WR_B);

  assign bus.HIADR   = exp_hit ? hiadr_new : hiadr_q;
  assign bus.RAMCS_B = !(acc && exp_hit);
  assign bus.RAMDIS  = acc && exp_hit;

endmodule

// File: tb/tb_cpc_ram_bank_decoder.sv
// tb/tb_cpc_ram_bank_decoder.sv - directed self-checking bench for cpc_ram_bank_decoder
module tb_cpc_ram_bank_decoder;

  logic CLK;
  logic RESET;
  int   checks;
  int   errors;

  cpc_ram_bank_decoder_if #(.HIADR_W(5)) bus ();

  cpc_ram_bank_decoder #(.BANK_BITS(3), .HIADR_W(5)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [4:0] e_hi, input logic e_cs, input logic e_dis);
    checks++;
    assert (bus.HIADR === e_hi) else begin
      errors++;
      $error("FAIL %s HIADR got %0d exp %0d", tag, bus.HIADR, e_hi);
    end
    checks++;
    assert (bus.RAMCS_B === e_cs) else begin
      errors++;
      $error("FAIL %s RAMCS_B got %b exp %b", tag, bus.RAMCS_B, e_cs);
    end
    checks++;
    assert (bus.RAMDIS === e_dis) else begin
      errors++;
      $error("FAIL %s RAMDIS got %b exp %b", tag, bus.RAMDIS, e_dis);
    end
  endtask

  task automatic idle_bus();
    bus.MREQ_B  = 1'b1;
    bus.IOREQ_B = 1'b1;
    bus.WR_B    = 1'b1;
    bus.RFSH_B  = 1'b1;
    bus.M1_B    = 1'b1;
    bus.RAMRD_B = 1'b1;
  endtask

  // Memory cycle set up at the falling edge, outputs settled 1ns later.
  task automatic mem(input logic a15, input logic a14, input logic mreq_b, input logic rfsh_b,
                     input logic ramrd_b, input logic wr_b, input logic m1_b);
    @(negedge CLK);
    idle_bus();
    bus.A15     = a15;
    bus.A14     = a14;
    bus.MREQ_B  = mreq_b;
    bus.RFSH_B  = rfsh_b;
    bus.RAMRD_B = ramrd_b;
    bus.WR_B    = wr_b;
    bus.M1_B    = m1_b;
    #1;
  endtask

  task automatic rd(input logic a15, input logic a14);
    mem(a15, a14, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  // OUT cycle; outputs checked while IOREQ is still low. Returns just after the
  // edge that samples IOREQ high (commit cycle in progress).
  task automatic io_write(input string tag, input logic a15, input logic a14, input logic [7:0] d,
                          input logic m1_b, input logic [4:0] exp_hi);
    @(negedge CLK);
    idle_bus();
    bus.A15     = a15;
    bus.A14     = a14;
    bus.D       = d;
    bus.M1_B    = m1_b;
    bus.IOREQ_B = 1'b0;
    bus.WR_B    = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk(tag, exp_hi, 1'b1, 1'b0);
    idle_bus();
    @(posedge CLK);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RESET  = 1'b1;
    idle_bus();
    bus.A15 = 1'b0;
    bus.A14 = 1'b0;
    bus.D   = 8'h00;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("in_reset", 5'd0, 1'b1, 1'b0);
    RESET = 1'b0;

    rd(1'b1, 1'b1);
    chk("rst_rd_c000", 5'd0, 1'b1, 1'b0);

    // bank0 mode1
    io_write("out_c1_during", 1'b0, 1'b1, 8'hC1, 1'b1, 5'd0);
    @(posedge CLK);
    rd(1'b1, 1'b1);
    chk("m1_rd_c000", 5'd3, 1'b0, 1'b1);
    rd(1'b0, 1'b1);
    chk("m1_rd_4000_hold", 5'd3, 1'b1, 1'b0);

    // bank7 mode2, access in the commit cycle still sees mode1/bank0
    io_write("out_fa_during", 1'b0, 1'b1, 8'hFA, 1'b1, 5'd3);
    rd(1'b1, 1'b1);
    chk("commit_cycle_old", 5'd3, 1'b0, 1'b1);
    @(posedge CLK);
    #1;
    chk("after_commit_new", 5'd31, 1'b0, 1'b1);
    rd(1'b0, 1'b0);
    chk("b7m2_0000", 5'd28, 1'b0, 1'b1);
    rd(1'b0, 1'b1);
    chk("b7m2_4000", 5'd29, 1'b0, 1'b1);
    rd(1'b1, 1'b0);
    chk("b7m2_8000", 5'd30, 1'b0, 1'b1);
    rd(1'b1, 1'b1);
    chk("b7m2_c000", 5'd31, 1'b0, 1'b1);

    // bank0 mode4
    io_write("out_c4_during", 1'b0, 1'b1, 8'hC4, 1'b1, 5'd29);
    @(posedge CLK);
    mem(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("rfsh_4000", 5'd0, 1'b1, 1'b0);
    mem(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("m1_fetch_4000", 5'd0, 1'b0, 1'b1);
    mem(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("rom_read_4000", 5'd0, 1'b1, 1'b0);
    mem(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("write_under_rom", 5'd0, 1'b0, 1'b1);

    // bank0 mode3: window1 is internal page3
    io_write("out_c3_during", 1'b0, 1'b1, 8'hC3, 1'b1, 5'd0);
    @(posedge CLK);
    rd(1'b0, 1'b1);
    chk("m3_4000_internal", 5'd0, 1'b1, 1'b0);
    rd(1'b1, 1'b1);
    chk("m3_c000", 5'd3, 1'b0, 1'b1);

    // back to mode0, then writes that must be ignored
    io_write("out_c0_during", 1'b0, 1'b1, 8'hC0, 1'b1, 5'd3);
    @(posedge CLK);
    io_write("out_bc_c2_during", 1'b1, 1'b0, 8'hC2, 1'b1, 5'd3);
    @(posedge CLK);
    rd(1'b0, 1'b1);
    chk("a15_ignored", 5'd3, 1'b1, 1'b0);
    io_write("out_82_during", 1'b0, 1'b1, 8'h82, 1'b1, 5'd3);
    @(posedge CLK);
    rd(1'b0, 1'b1);
    chk("d76_ignored", 5'd3, 1'b1, 1'b0);
    io_write("intack_during", 1'b0, 1'b1, 8'hC2, 1'b0, 5'd3);
    @(posedge CLK);
    rd(1'b0, 1'b1);
    chk("intack_ignored_4000", 5'd3, 1'b1, 1'b0);
    rd(1'b1, 1'b1);
    chk("intack_ignored_c000", 5'd3, 1'b1, 1'b0);

    // reset while the OUT is pending discards it
    @(negedge CLK);
    idle_bus();
    bus.A15     = 1'b0;
    bus.A14     = 1'b1;
    bus.D       = 8'hC2;
    bus.IOREQ_B = 1'b0;
    bus.WR_B    = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    idle_bus();
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    rd(1'b0, 1'b1);
    chk("rst_wait_4000", 5'd0, 1'b1, 1'b0);
    rd(1'b1, 1'b1);
    chk("rst_wait_c000", 5'd0, 1'b1, 1'b0);

    @(negedge CLK);
    idle_bus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
